mem_io_bridge: RTL and testbench
================================

# mem_io_bridge

Memory-side companion to the SLC-3 CPU: consumes the CPU's memory request (`mem_addr`, `mem_wdata`, `mem_mem_ena`, `mem_wr_ena`) and returns `mem_rdata`. It decodes each access to either the on-chip program/data BRAM or the memory-mapped I/O register at `16'hFFFF`. That register holds the switch input on read and the hex display value on write. It also drives the 4-digit multiplexed seven-segment display from that register.

## Interface
Parameters:
- `IO_ADDR`, `16'hFFFF`: memory-mapped I/O address.
- `SCAN_W`, 16: width of the display scan counter; the digit advances every 2^(SCAN_W-2) cycles.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk`).
- `mem_addr`  in  16  CPU access address.
- `mem_wdata`  in  16  CPU write data.
- `mem_mem_ena`  in  1  access request, level.
- `mem_wr_ena`  in  1  1 = write, 0 = read; qualified by `mem_mem_ena`.
- `mem_rdata`  out  16  registered read data to the CPU.
- `bram_addr`  out  16  BRAM address; combinational pass of `mem_addr`.
- `bram_wdata`  out  16  BRAM write data; combinational pass of `mem_wdata`.
- `bram_en`  out  1  BRAM enable.
- `bram_we`  out  1  BRAM write enable.
- `bram_rdata`  in  16  BRAM read data, valid 1 cycle after `bram_en`.
- `sw_i`  in  16  asynchronous slide switches.
- `hex_reg_o`  out  16  current display register.
- `hex_seg_o`  out  8  segments a–g, dp; active-low.
- `hex_grid_o`  out  4  digit enables, active-low, one-hot-low.

## Operation
- Decode: `is_io` = (`mem_addr` == `IO_ADDR`).
  - `bram_en` = `mem_mem_ena` & !`is_io`.
  - `bram_we` = `bram_en` & `mem_wr_ena`.
  - A BRAM is never enabled for an I/O access.
- Switch sync: 2-flop synchronizer `sw_i` → `sw_q`; reset clears to 0.
- I/O write (`mem_mem_ena` & `mem_wr_ena` & `is_io`): `hex_reg` ← `mem_wdata` on that edge.
- Read return: on a read request, register `src_io` = `is_io` (1-cycle pipeline).
  - The next cycle, `mem_rdata` loads `sw_q` if `src_io`, else `bram_rdata`.
  - `mem_rdata` holds its value until the next read completes. Writes and idle cycles do not change it.
- Read FSM, 2 states:
  - IDLE: a read request → WAIT.
  - WAIT: capture `mem_rdata`. Still requesting a read → stay WAIT, which re-captures each cycle. Otherwise → IDLE.
- A sustained `mem_mem_ena` read therefore tracks the address with 1-cycle lag. The CPU control holds the request ≥2 cycles, so `mdr` captures settled data.
- Display scan: free-running `scan_cnt` of `SCAN_W` bits, wrapping.
  - `digit` = `scan_cnt[SCAN_W-1:SCAN_W-2]`.
  - `hex_grid_o` = ~(4'b0001 << `digit`).
  - `hex_seg_o` = active-low pattern for nibble `hex_reg[4*digit+3:4*digit]`; digits 0–F, dp always off (bit 7 = 1).

## Timing
- Reset (`reset`==0 at an edge):
  - `mem_rdata`=0, `hex_reg`=0, `sw_q`=0, `scan_cnt`=0, FSM=IDLE.
  - Outputs: `hex_grid_o`=4'b1110, `hex_seg_o`=8'hC0 (digit "0").
  - Reset overrides any simultaneous request. A read in flight when reset asserts is dropped.
- BRAM read: request at cycle N → `bram_rdata` at N+1 → `mem_rdata` valid after edge N+1 (latency 2 edges from request).
- I/O read: same 2-edge latency. Switch change to visible `mem_rdata` ≤ 2 sync edges + read latency.
- Write: single cycle, no stall. A read at cycle N+1 of the same BRAM address returns the new data (BRAM write-first).
- Write then read of `IO_ADDR`: the read returns switches, never `hex_reg`. The I/O address is write/read asymmetric.
- `mem_wr_ena` without `mem_mem_ena`: no effect.
- Address 16'hFFFE and below: BRAM. 16'hFFFF: I/O only.

## Structure
- Package `slc3_mmio_pkg`: `IO_ADDR` constant, `seg7_t` typedef (logic [7:0]), `SEG_LUT[16]` active-low segment constants, and the `rd_state_e` {IDLE, WAIT} enum.
- Sub-module `hex_driver` (`clk`, `reset`, `hex_reg`, `hex_seg_o`, `hex_grid_o`) holds the scan counter and decoder. The bridge top holds decode, sync, FSM and `hex_reg`.

## Test plan
- Reset with `reset`=0 while `mem_mem_ena`=1, `mem_wr_ena`=1, addr FFFF, data 1234 → `hex_reg_o`=0, `mem_rdata`=0, `hex_grid_o`=1110, `hex_seg_o`=C0.
- Write BRAM addr 0x0010 ← 0xBEEF, then read 0x0010 → `bram_we` high 1 cycle; `mem_rdata`=BEEF 2 edges after the read request; `bram_en` low for all FFFF accesses.
- Set `sw_i`=0x00A5, wait 3 cycles, read FFFF → `mem_rdata`=00A5; `bram_en` stays 0.
- Write FFFF ← 0x1234 → `hex_reg_o`=1234. Read FFFF with `sw_i`=0 → `mem_rdata`=0000, `hex_reg_o` unchanged.
- `hex_reg`=0x1234, SCAN_W=4: step 16 cycles → grid sequence 1110/1101/1011/0111, each held 4 cycles. Segments: digit 0 "4"=0x99, digit 1 "3"=0xB0, digit 2 "2"=0xA4, digit 3 "1"=0xF9. Wraps to digit 0.
- Back-to-back reads 0x0001 then 0x0002 (values 0x1111, 0x2222), each held 2 cycles; then an idle cycle → `mem_rdata` ends at 2222 and holds through idle and a following write.

Source files
------------

// File: rtl/slc3_mmio_pkg.sv
// Shared constants and types for the SLC-3 memory/IO bridge:
// the I/O register address, seven-segment lookup and read-FSM states.
package slc3_mmio_pkg;

    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    typedef logic [7:0] seg7_t;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp is always dark.
    localparam seg7_t SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } rd_state_e;

endpackage

// File: rtl/mem_io_bridge_hex_driver.sv
// Four-digit multiplexed seven-segment driver: a free-running scan counter
// selects one nibble of the display register per digit slot.
module hex_driver #(
    parameter int SCAN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hex_reg,
    output logic [7:0]  hex_seg_o,
    output logic [3:0]  hex_grid_o
);
    import slc3_mmio_pkg::*;

    logic [SCAN_W-1:0] scan_cnt_q;
    logic [SCAN_W-1:0] scan_cnt_d;
    logic [1:0]        digit;
    logic [3:0]        nibble;

    always_comb begin
        scan_cnt_d = scan_cnt_q + {{(SCAN_W-1){1'b0}}, 1'b1};
        digit      = scan_cnt_q[SCAN_W-1 -: 2];
        nibble     = hex_reg[{digit, 2'b00} +: 4];
        hex_grid_o = ~(4'b0001 << digit);
        hex_seg_o  = SEG_LUT[nibble];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// SLC-3 memory-side bridge: routes CPU accesses to BRAM or the switch/hex
// I/O register, returns registered read data, and drives the hex display.
module mem_io_bridge #(
    parameter logic [15:0] IO_ADDR = slc3_mmio_pkg::IO_ADDR,
    parameter int          SCAN_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_mem_ena,
    input  logic        mem_wr_ena,
    output logic [15:0] mem_rdata,
    output logic [15:0] bram_addr,
    output logic [15:0] bram_wdata,
    output logic        bram_en,
    output logic        bram_we,
    input  logic [15:0] bram_rdata,
    input  logic [15:0] sw_i,
    output logic [15:0] hex_reg_o,
    output logic [7:0]  hex_seg_o,
    output logic [3:0]  hex_grid_o
);
    import slc3_mmio_pkg::*;

    logic        is_io;
    logic        rd_req;
    logic        io_wr;

    rd_state_e   state_q, state_d;
    logic        src_io_q, src_io_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic [15:0] hex_reg_q, hex_reg_d;
    logic [15:0] sw_meta_q, sw_meta_d;
    logic [15:0] sw_q, sw_d;

    always_comb begin
        is_io      = (mem_addr == IO_ADDR);
        rd_req     = mem_mem_ena & ~mem_wr_ena;
        io_wr      = mem_mem_ena & mem_wr_ena & is_io;
        bram_addr  = mem_addr;
        bram_wdata = mem_wdata;
        bram_en    = mem_mem_ena & ~is_io;
        bram_we    = bram_en & mem_wr_ena;
    end

    always_comb begin
        state_d     = state_q;
        src_io_d    = src_io_q;
        mem_rdata_d = mem_rdata_q;
        hex_reg_d   = hex_reg_q;
        sw_meta_d   = sw_i;
        sw_d        = sw_meta_q;

        if (io_wr) begin
            hex_reg_d = mem_wdata;
        end

        // Source select is latched with the request so the capture next cycle
        // matches the BRAM's one-cycle read latency.
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d  = WAIT;
                    src_io_d = is_io;
                end
            end
            WAIT: begin
                mem_rdata_d = src_io_q ? sw_q : bram_rdata;
                if (rd_req) begin
                    src_io_d = is_io;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            src_io_q    <= 1'b0;
            mem_rdata_q <= '0;
            hex_reg_q   <= '0;
            sw_meta_q   <= '0;
            sw_q        <= '0;
        end else begin
            state_q     <= state_d;
            src_io_q    <= src_io_d;
            mem_rdata_q <= mem_rdata_d;
            hex_reg_q   <= hex_reg_d;
            sw_meta_q   <= sw_meta_d;
            sw_q        <= sw_d;
        end
    end

    assign mem_rdata = mem_rdata_q;
    assign hex_reg_o = hex_reg_q;

    hex_driver #(
        .SCAN_W (SCAN_W)
    ) u_hex_driver (
        .clk        (clk),
        .reset      (reset),
        .hex_reg    (hex_reg_q),
        .hex_seg_o  (hex_seg_o),
        .hex_grid_o (hex_grid_o)
    );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge with a small write-first BRAM model.
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_mem_ena, mem_wr_ena;
    logic [15:0] mem_rdata;
    logic [15:0] bram_addr, bram_wdata;
    logic        bram_en, bram_we;
    logic [15:0] bram_rdata;
    logic [15:0] sw_i;
    logic [15:0] hex_reg_o;
    logic [7:0]  hex_seg_o;
    logic [3:0]  hex_grid_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] exp_q [$];
    logic p1 = 1'b0;
    logic p2 = 1'b0;

    logic [15:0] bram_mem [0:255];

    always #5 clk = ~clk;

    mem_io_bridge #(
        .IO_ADDR (16'hFFFF),
        .SCAN_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_mem_ena (mem_mem_ena),
        .mem_wr_ena  (mem_wr_ena),
        .mem_rdata   (mem_rdata),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_rdata  (bram_rdata),
        .sw_i        (sw_i),
        .hex_reg_o   (hex_reg_o),
        .hex_seg_o   (hex_seg_o),
        .hex_grid_o  (hex_grid_o)
    );

    // Write-first synchronous BRAM
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                bram_mem[bram_addr[7:0]] <= bram_wdata;
                bram_rdata <= bram_wdata;
            end else begin
                bram_rdata <= bram_mem[bram_addr[7:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A read request seen in cycle k is captured two edges later.
    always @(negedge clk) begin
        logic [15:0] e;
        if (p2) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_sb_empty: got data %h, expected no read pending", mem_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", mem_rdata, e);
            end
        end
        p2 = p1;
        p1 = reset && mem_mem_ena && !mem_wr_ena;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_mem_ena = 1'b0;
        mem_wr_ena  = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        mem_addr    = a;
        mem_wdata   = d;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = 1'b1;
        @(negedge clk);
        chk("wr_bram_en", {15'd0, bram_en}, {15'd0, a != 16'hFFFF});
        chk("wr_bram_we", {15'd0, bram_we}, {15'd0, a != 16'hFFFF});
        step();
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            mem_addr    = a;
            mem_mem_ena = 1'b1;
            mem_wr_ena  = 1'b0;
            exp_q.push_back(exp);
            @(negedge clk);
            chk("rd_bram_en", {15'd0, bram_en}, {15'd0, a != 16'hFFFF});
            chk("rd_bram_we", {15'd0, bram_we}, 16'd0);
            step();
        end
    endtask

    initial begin
        logic [7:0] seg_exp [4];
        logic [3:0] prev_grid;
        logic [3:0] g_exp;
        bit found;
        seg_exp[0] = 8'h99;
        seg_exp[1] = 8'hB0;
        seg_exp[2] = 8'hA4;
        seg_exp[3] = 8'hF9;
        for (int i = 0; i < 256; i++) bram_mem[i] = 16'h0;
        bram_rdata = 16'h0;
        sw_i = 16'h0;

        // Reset overrides a simultaneous I/O write
        reset       = 1'b0;
        mem_addr    = 16'hFFFF;
        mem_wdata   = 16'h1234;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_hex_reg", hex_reg_o, 16'h0000);
        chk("rst_rdata", mem_rdata, 16'h0000);
        chk("rst_grid", {12'd0, hex_grid_o}, 16'h000E);
        chk("rst_seg", {8'd0, hex_seg_o}, 16'h00C0);
        step();
        reset = 1'b1;
        idle(2);

        // BRAM write then read-back
        do_write(16'h0010, 16'hBEEF);
        mem_mem_ena = 1'b0;
        mem_wr_ena  = 1'b0;
        @(negedge clk);
        chk("we_one_cycle", {15'd0, bram_we}, 16'd0);
        step();
        do_read(16'h0010, 16'hBEEF, 2);
        idle(3);

        // Switch read through the synchronizer
        sw_i = 16'h00A5;
        idle(3);
        do_read(16'hFFFF, 16'h00A5, 2);
        idle(3);

        // I/O write is visible on the display, not on read-back
        do_write(16'hFFFF, 16'h1234);
        chk("io_wr_hex", hex_reg_o, 16'h1234);
        sw_i = 16'h0000;
        idle(3);
        do_read(16'hFFFF, 16'h0000, 2);
        idle(3);
        chk("io_rd_hex_keep", hex_reg_o, 16'h1234);

        // Align to the start of digit 0, then walk a full scan and the wrap
        found = 1'b0;
        @(negedge clk);
        prev_grid = hex_grid_o;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (hex_grid_o == 4'b1110 && prev_grid != 4'b1110) found = 1'b1;
            prev_grid = hex_grid_o;
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL scan_align: got grid %b, expected a 1110 start within 40 cycles", hex_grid_o);
        end else begin
            for (int j = 0; j <= 16; j++) begin
                if (j > 0) @(negedge clk);
                g_exp = ~(4'b0001 << ((j / 4) % 4));
                chk("scan_grid", {12'd0, hex_grid_o}, {12'd0, g_exp});
                chk("scan_seg", {8'd0, hex_seg_o}, {8'd0, seg_exp[(j / 4) % 4]});
            end
        end
        step();

        // Back-to-back reads, then hold through idle and a write
        do_write(16'h0001, 16'h1111);
        do_write(16'h0002, 16'h2222);
        idle(1);
        do_read(16'h0001, 16'h1111, 2);
        do_read(16'h0002, 16'h2222, 2);
        idle(2);
        @(negedge clk);
        chk("hold_idle", mem_rdata, 16'h2222);
        step();
        do_write(16'h0003, 16'h5555);
        idle(1);
        @(negedge clk);
        chk("hold_write", mem_rdata, 16'h2222);
        step();
        idle(3);

        chk("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
